rv32i_decode_core: RTL and testbench
====================================

Name: rv32i_decode_core

Overview:
- Combinational/storage core of the RV32I decode stage.
- Contains three parts:
  - control unit: main decoder from opcode/funct3/funct7.
  - immediate generator: sign-extended immediate per format.
  - 32x32 register file: two read ports, one write-back port.
- The surrounding decode pipeline register registers its outputs into the execute stage; writes arrive from the writeback stage.

Parameters:
- XLEN, 32, data/register width (only 32 supported).
- NREGS, 32, number of architectural registers (x0..x31).

Ports:
- clk  in  1  clock; register-file writes on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- instruction  in  32  instruction word under decode.
- wb_addr  in  5  write-back register index.
- wb_data  in  32  write-back data.
- wb_en  in  1  write-back enable.
- dump  in  1  debug register print request.
- rs1, rs2, rd  out  5 each  instruction[19:15], [24:20], [11:7].
- funct3  out  3  instruction[14:12].
- rs1_val, rs2_val  out  32 each  register read data.
- regs  out  32x32  full register-file contents (unpacked array).
- alu_op  out  4  ALU operation code.
- mem_read, mem_write, reg_write, use_imm, is_branch, is_jump, is_jalr, is_final  out  1 each  control flags.
- instr_type  out  3  format: R=0, I=1, S=2, B=3, U=4, J=5.
- sext_imm  out  32  sign-extended immediate.

Behaviour:
- Register file:
  - reset_n low clears all 32 registers to 0 asynchronously.
  - Write: on posedge clk when wb_en=1 and wb_addr!=0, reg[wb_addr] <= wb_data. Writes to x0 are discarded, so x0 always reads 0.
  - Reads are combinational.
  - Same-cycle bypass: if wb_en=1, wb_addr!=0 and wb_addr equals the read index, the read port returns wb_data.
  - regs[] reflects stored state only, without bypass.
- alu_op codes: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10.
- Control unit is purely combinational. Any flag not listed for a row below is 0.
  - OP (0110011): R; reg_write. funct3 maps 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND. funct7[5]=1 selects SUB/SRA.
  - OP-IMM (0010011): I; reg_write, use_imm. Same funct3 map. funct7[5] is honoured only for funct3=101 (SRAI); ADDI never becomes SUB.
  - LOAD (0000011): I; mem_read, reg_write, use_imm, ADD.
  - STORE (0100011): S; mem_write, use_imm, ADD.
  - BRANCH (1100011): B; is_branch, SUB; the comparison type is carried by funct3.
  - JAL (1101111): J; is_jump, reg_write, use_imm, ADD.
  - JALR (1100111): I; is_jump, is_jalr, reg_write, use_imm, ADD.
  - LUI (0110111): U; reg_write, use_imm, PASSB.
  - AUIPC (0010111): U; reg_write, use_imm, ADD. Execute selects pc as operand A.
  - SYSTEM (1110011): I; is_final=1, all other flags 0.
  - FENCE (0001111) and every unknown opcode: I, all flags 0, alu_op ADD (NOP).
- Immediate generator (combinational, from instr_type):
  - I: sext(ins[31:20]).
  - S: sext({ins[31:25], ins[11:7]}).
  - B: sext({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}).
  - U: {ins[31:12], 12'b0}.
  - J: sext({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}).
  - R: 0.
- Field outputs (rs1/rs2/rd/funct3) are raw slices, valid for every format.
- Reset affects only register contents. Decode outputs stay combinational functions of instruction during reset, with read data 0.

Optional Feature:
- Macro REGFILE_DUMP_EN.
- When defined: at each posedge clk with dump=1, print all 32 registers ("xN = 0xHHHHHHHH", decimal index, 8 hex digits) using pre-edge contents.
- When undefined: dump is accepted and ignored; no simulation output; identical functional behaviour.

Test Plan:
- Reset, then write x1=5, x2=7; instruction 0x002081B3 (add x3,x1,x2) -> rs1_val=5, rs2_val=7, R, alu_op=ADD, reg_write=1, use_imm=0.
- wb_en=1, wb_addr=0, wb_data=0xDEAD -> x0 still reads 0. Same cycle wb_addr=4, wb_data=0x1234 with rs1=4 -> rs1_val=0x1234 (bypass) before the edge.
- 0xFFF00093 (addi x1,x0,-1) -> sext_imm=0xFFFFFFFF, I, use_imm=1. 0x4030D093 (srai x1,x1,3) -> alu_op=SRA, sext_imm=0x403.
- 0xFE000EE3 (beq x0,x0,-4) -> B, is_branch=1, sext_imm=0xFFFFFFFC. 0x0080006F (jal x0,8) -> J, is_jump=1, sext_imm=8.
- 0x12345037 (lui) -> U, PASSB, sext_imm=0x12345000. 0x00000073 (ecall) -> is_final=1, reg_write=0.
- Registers loaded, reset_n pulsed low mid-cycle -> all regs read 0 immediately, no clock edge needed.

Source files
------------

// File: rtl/rv32i_decode_core_if.sv
// rtl/rv32i_decode_core_if.sv - write-back bus from the writeback stage into the decode register file
interface rv32i_decode_core_if #(
    parameter int XLEN = 32
);
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            wb_en;

    modport master (output wb_addr, output wb_data, output wb_en);
    modport slave  (input  wb_addr, input  wb_data, input  wb_en);
endinterface

// File: rtl/rv32i_decode_core.sv
// rtl/rv32i_decode_core.sv - RV32I decode stage: control unit, immediate generator, 32x32 register file
// Optional register print on dump is built only with REGFILE_DUMP_EN defined.
module rv32i_decode_core #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          instruction,
    rv32i_decode_core_if.slave   wb,
    input  logic                 dump,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [4:0]           rd,
    output logic [2:0]           funct3,
    output logic [XLEN-1:0]      rs1_val,
    output logic [XLEN-1:0]      rs2_val,
    output logic [XLEN-1:0]      regs [NREGS],
    output logic [3:0]           alu_op,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic                 use_imm,
    output logic                 is_branch,
    output logic                 is_jump,
    output logic                 is_jalr,
    output logic                 is_final,
    output logic [2:0]           instr_type,
    output logic [XLEN-1:0]      sext_imm
);
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;
    localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3, T_U = 3'd4, T_J = 3'd5;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            wb_hit;

    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign wb_hit = wb.wb_en && (wb.wb_addr != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (wb_hit)
            regs_d[wb.wb_addr] = wb.wb_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign regs = regs_q;

    // Bypass lets decode see a value being written back this cycle; reads are forced to 0 in reset.
    assign rs1_val = !reset_n ? '0 : (wb_hit && wb.wb_addr == rs1) ? wb.wb_data : regs_q[rs1];
    assign rs2_val = !reset_n ? '0 : (wb_hit && wb.wb_addr == rs2) ? wb.wb_data : regs_q[rs2];

    function automatic logic [3:0] f3_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        alu_op     = ALU_ADD;
        instr_type = T_I;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        use_imm    = 1'b0;
        is_branch  = 1'b0;
        is_jump    = 1'b0;
        is_jalr    = 1'b0;
        is_final   = 1'b0;
        case (instruction[6:0])
            7'b0110011: begin
                instr_type = T_R; reg_write = 1'b1;
                alu_op = f3_alu(funct3, instruction[30]);
            end
            7'b0010011: begin
                reg_write = 1'b1; use_imm = 1'b1;
                alu_op = f3_alu(funct3, instruction[30] && funct3 == 3'b101);
            end
            7'b0000011: begin mem_read = 1'b1; reg_write = 1'b1; use_imm = 1'b1; end
            7'b0100011: begin instr_type = T_S; mem_write = 1'b1; use_imm = 1'b1; end
            7'b1100011: begin instr_type = T_B; is_branch = 1'b1; alu_op = ALU_SUB; end
            7'b1101111: begin instr_type = T_J; is_jump = 1'b1; reg_write = 1'b1; use_imm = 1'b1; end
            7'b1100111: begin is_jump = 1'b1; is_jalr = 1'b1; reg_write = 1'b1; use_imm = 1'b1; end
            7'b0110111: begin instr_type = T_U; reg_write = 1'b1; use_imm = 1'b1; alu_op = ALU_PASSB; end
            7'b0010111: begin instr_type = T_U; reg_write = 1'b1; use_imm = 1'b1; end
            7'b1110011: is_final = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        case (instr_type)
            T_I:     sext_imm = {{20{instruction[31]}}, instruction[31:20]};
            T_S:     sext_imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            T_B:     sext_imm = {{19{instruction[31]}}, instruction[31], instruction[7],
                                 instruction[30:25], instruction[11:8], 1'b0};
            T_U:     sext_imm = {instruction[31:12], 12'b0};
            T_J:     sext_imm = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                                 instruction[20], instruction[30:21], 1'b0};
            default: sext_imm = '0;
        endcase
    end

`ifdef REGFILE_DUMP_EN
    // Sampled at the edge, so the printout shows contents from before this cycle's write.
    always @(posedge clk) begin
        if (dump) begin
            for (int i = 0; i < NREGS; i++)
                $display("x%0d = 0x%08h", i, regs_q[i]);
        end
    end
`else
    logic unused_dump;
    assign unused_dump = dump;
`endif
endmodule

// File: tb/tb_rv32i_decode_core.sv
// tb/tb_rv32i_decode_core.sv - self-checking bench for rv32i_decode_core
module tb_rv32i_decode_core;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        dump;
    logic [31:0] instruction;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val, sext_imm;
    logic [31:0] regs [32];
    logic [3:0]  alu_op;
    logic        mem_read, mem_write, reg_write, use_imm;
    logic        is_branch, is_jump, is_jalr, is_final;
    logic [2:0]  instr_type;

    int checks = 0;
    int errors = 0;
    logic [31:0] mregs [32];

    typedef struct packed {
        logic [3:0]  alu;
        logic [2:0]  typ;
        logic [7:0]  flags;  // mem_read,mem_write,reg_write,use_imm,is_branch,is_jump,is_jalr,is_final
        logic [31:0] imm;
    } exp_t;

    rv32i_decode_core_if wb ();

    rv32i_decode_core dut (
        .clk(clk), .reset_n(reset_n), .instruction(instruction), .wb(wb.slave), .dump(dump),
        .rs1(rs1), .rs2(rs2), .rd(rd), .funct3(funct3), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .regs(regs), .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .use_imm(use_imm), .is_branch(is_branch), .is_jump(is_jump),
        .is_jalr(is_jalr), .is_final(is_final), .instr_type(instr_type), .sext_imm(sext_imm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] amap(input int f3, input bit alt);
        logic [3:0] tbl [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        if (alt && f3 == 0) return 4'd1;
        if (alt && f3 == 5) return 4'd7;
        return tbl[f3];
    endfunction

    function automatic exp_t ref_dec(input logic [31:0] ins);
        exp_t e;
        int   imm;
        int   f3;
        bit   alt;
        f3 = int'(ins[14:12]);
        alt = ins[30];
        e = '0;
        e.typ = 3'd1;
        case (ins[6:0])
            7'h33: begin e.typ = 3'd0; e.flags = 8'b0010_0000; e.alu = amap(f3, alt); end
            7'h13: begin e.flags = 8'b0011_0000; e.alu = amap(f3, alt && f3 == 5); end
            7'h03: e.flags = 8'b1011_0000;
            7'h23: begin e.typ = 3'd2; e.flags = 8'b0101_0000; end
            7'h63: begin e.typ = 3'd3; e.flags = 8'b0000_1000; e.alu = 4'd1; end
            7'h6F: begin e.typ = 3'd5; e.flags = 8'b0011_0100; end
            7'h67: e.flags = 8'b0011_0110;
            7'h37: begin e.typ = 3'd4; e.flags = 8'b0011_0000; e.alu = 4'd10; end
            7'h17: begin e.typ = 3'd4; e.flags = 8'b0011_0000; end
            7'h73: e.flags = 8'b0000_0001;
            default: ;
        endcase
        imm = 0;
        case (e.typ)
            3'd1: begin imm = int'(ins[31:20]); if (imm >= 2048) imm -= 4096; end
            3'd2: begin imm = int'(ins[31:25]) * 32 + int'(ins[11:7]); if (imm >= 2048) imm -= 4096; end
            3'd3: begin
                imm = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
                if (imm >= 4096) imm -= 8192;
            end
            3'd4: imm = int'(ins[31:12]) * 4096;
            3'd5: begin
                imm = int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                    + int'(ins[30:21]) * 2;
                if (imm >= (1 << 20)) imm -= (1 << 21);
            end
            default: imm = 0;
        endcase
        e.imm = 32'(imm);
        return e;
    endfunction

    task automatic chk_dec(input string tag);
        exp_t e;
        e = ref_dec(instruction);
        chk({tag, ".alu_op"}, 32'(alu_op), 32'(e.alu));
        chk({tag, ".type"}, 32'(instr_type), 32'(e.typ));
        chk({tag, ".flags"}, 32'({mem_read, mem_write, reg_write, use_imm, is_branch, is_jump, is_jalr, is_final}),
            32'(e.flags));
        chk({tag, ".imm"}, sext_imm, e.imm);
        chk({tag, ".fields"}, {9'd0, rs1, rs2, rd, funct3, 5'd0},
            {9'd0, instruction[19:15], instruction[24:20], instruction[11:7], instruction[14:12], 5'd0});
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (wb.wb_en && wb.wb_addr != 0 && wb.wb_addr == idx) return wb.wb_data;
        return mregs[idx];
    endfunction

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wb.wb_en = 1'b1; wb.wb_addr = a; wb.wb_data = d;
        @(posedge clk);
        if (a != 0) mregs[a] = d;
        #1 wb.wb_en = 1'b0;
    endtask

    initial begin
        logic [6:0]  ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0F};
        logic [31:0] r;
        logic [6:0]  op;
        int          k;

        for (int i = 0; i < 32; i++) mregs[i] = '0;
        reset_n = 1'b0; dump = 1'b0; instruction = 32'h0;
        wb.wb_en = 1'b0; wb.wb_addr = 5'd0; wb.wb_data = 32'h0;
        #12;
        chk("reset.x5", regs[5], 32'h0);
        chk("reset.rs1_val", rs1_val, 32'h0);
        reset_n = 1'b1;

        wr(5'd1, 32'd5);
        wr(5'd2, 32'd7);
        instruction = 32'h002081B3; #1;
        chk("add.rs1_val", rs1_val, 32'd5);
        chk("add.rs2_val", rs2_val, 32'd7);
        chk("add.alu_op", 32'(alu_op), 32'd0);
        chk("add.type", 32'(instr_type), 32'd0);
        chk("add.reg_write_use_imm", {30'd0, reg_write, use_imm}, 32'b10);
        chk_dec("add");

        @(negedge clk);
        wb.wb_en = 1'b1; wb.wb_addr = 5'd0; wb.wb_data = 32'hDEAD; instruction = 32'h00000033; #1;
        chk("x0_write.rs1_val", rs1_val, 32'h0);
        @(posedge clk); #1;
        chk("x0_write.regs0", regs[0], 32'h0);
        @(negedge clk);
        wb.wb_addr = 5'd4; wb.wb_data = 32'h1234; instruction = 32'h00020033; #1;
        chk("bypass.rs1_val", rs1_val, 32'h1234);
        chk("bypass.regs4_prewrite", regs[4], 32'h0);
        @(posedge clk); mregs[4] = 32'h1234; #1;
        wb.wb_en = 1'b0;
        chk("bypass.regs4_written", regs[4], 32'h1234);

        instruction = 32'hFFF00093; #1;
        chk("addi.imm", sext_imm, 32'hFFFFFFFF);
        chk("addi.type_use_imm", {28'd0, instr_type, use_imm}, {28'd0, 3'd1, 1'b1});
        instruction = 32'h4030D093; #1;
        chk("srai.alu_op", 32'(alu_op), 32'd7);
        chk("srai.imm", sext_imm, 32'h403);
        instruction = 32'h40008093; #1;
        chk("addi_f7.alu_op", 32'(alu_op), 32'd0);
        instruction = 32'hFE000EE3; #1;
        chk("beq.type_branch", {28'd0, instr_type, is_branch}, {28'd0, 3'd3, 1'b1});
        chk("beq.imm", sext_imm, 32'hFFFFFFFC);
        instruction = 32'h0080006F; #1;
        chk("jal.type_jump", {28'd0, instr_type, is_jump}, {28'd0, 3'd5, 1'b1});
        chk("jal.imm", sext_imm, 32'd8);
        instruction = 32'h12345037; #1;
        chk("lui.type_alu", {25'd0, instr_type, alu_op}, {25'd0, 3'd4, 4'd10});
        chk("lui.imm", sext_imm, 32'h12345000);
        instruction = 32'h00000073; #1;
        chk("ecall.final_rw", {30'd0, is_final, reg_write}, 32'b10);

        for (int it = 0; it < 300; it++) begin
            @(negedge clk);
            r = $urandom;
            k = $urandom_range(0, 11);
            if (k == 11) op = 7'($urandom);
            else op = ops[k];
            instruction = {r[31:7], op};
            wb.wb_en = 1'($urandom);
            wb.wb_addr = ($urandom_range(0, 3) == 0) ? instruction[19:15] : 5'($urandom);
            wb.wb_data = $urandom;
            dump = 1'($urandom);
            #1;
            chk_dec("rand");
            chk("rand.rs1_val", rs1_val, exp_read(instruction[19:15]));
            chk("rand.rs2_val", rs2_val, exp_read(instruction[24:20]));
            @(posedge clk);
            if (wb.wb_en && wb.wb_addr != 0) mregs[wb.wb_addr] = wb.wb_data;
            #1;
            k = $urandom_range(0, 31);
            chk("rand.regs", regs[k], mregs[k]);
        end

        @(negedge clk);
        wb.wb_en = 1'b0; dump = 1'b0;
        for (int i = 0; i < 32; i++) chk("preclear.regs", regs[i], mregs[i]);
        wr(5'd9, 32'hCAFE0009);
        instruction = 32'h0004A503;
        @(posedge clk); #2;
        reset_n = 1'b0; #1;
        for (int i = 0; i < 32; i++) chk("async_reset.regs", regs[i], 32'h0);
        chk("async_reset.rs1_val", rs1_val, 32'h0);
        chk_dec("async_reset");
        #1 reset_n = 1'b1;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        wr(5'd31, 32'h80000001);
        instruction = 32'h01F00033; #1;
        chk("post_reset.rs2_val", rs2_val, 32'h80000001);
        chk("post_reset.rs1_val", rs1_val, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
